// File: rtl/seq_shift_right_if.sv
// Operand/result bundle for the multi-cycle shifter.
// Optional SEQ_SHIFT_LEFT_EN adds the `left` direction select.
interface seq_shift_right_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   in;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
`ifdef SEQ_SHIFT_LEFT_EN
  logic               left;
`endif
  logic [WIDTH-1:0]   out;
  logic               busy;
  logic               done;

`ifdef SEQ_SHIFT_LEFT_EN
  modport master (output start, in, shamt, arith, left, input out, busy, done);
  modport slave  (input start, in, shamt, arith, left, output out, busy, done);
`else
  modport master (output start, in, shamt, arith, input out, busy, done);
  modport slave  (input start, in, shamt, arith, output out, busy, done);
`endif
endinterface

// File: rtl/seq_shift_right.sv
// Multi-cycle shifter: one bit per clock, start/done handshake.
// Right shifts (SRL/SRLV/SRA/SRAV) always; logical left shifts (SLL/SLLV)
// are added when SEQ_SHIFT_LEFT_EN is defined.
module seq_shift_right #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic             clk,
  input logic             rst,
  seq_shift_right_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               fill_mode_q, fill_mode_d;
  logic               busy_q, done_q;
  logic               fill;
`ifdef SEQ_SHIFT_LEFT_EN
  logic               left_q, left_d;
`endif

  // Sign bit is replicated only in arithmetic mode.
  assign fill = fill_mode_q & out_q[WIDTH-1];

  // Next-state: accept in IDLE/DONE, shift one bit per cycle in SHIFT.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    count_d     = count_q;
    fill_mode_d = fill_mode_q;
`ifdef SEQ_SHIFT_LEFT_EN
    left_d      = left_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          out_d       = bus.in;
          count_d     = bus.shamt;
          fill_mode_d = bus.arith;
`ifdef SEQ_SHIFT_LEFT_EN
          left_d      = bus.left;
`endif
          state_d     = (bus.shamt == '0) ? StDone : StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
`ifdef SEQ_SHIFT_LEFT_EN
        if (left_q) begin
          out_d = {out_q[WIDTH-2:0], 1'b0};
        end else begin
          out_d = {fill, out_q[WIDTH-1:1]};
        end
`else
        out_d = {fill, out_q[WIDTH-1:1]};
`endif
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_q       <= '0;
      count_q     <= '0;
      fill_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_SHIFT_LEFT_EN
      left_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      count_q     <= count_d;
      fill_mode_q <= fill_mode_d;
      busy_q      <= (state_d == StShift);
      done_q      <= (state_d == StDone);
`ifdef SEQ_SHIFT_LEFT_EN
      left_q      <= left_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed bench for seq_shift_right: vector table plus hand-written
// back-to-back, start-while-busy and async-reset sequences.
module tb_seq_shift_right;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_shift_right_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  seq_shift_right #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] din;
    logic [4:0]  sh;
    logic        ar;
    logic        lf;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] d, input logic [4:0] s,
                       input logic a, input logic l);
    bus.start = st;
    bus.in    = d;
    bus.shamt = s;
    bus.arith = a;
`ifdef SEQ_SHIFT_LEFT_EN
    bus.left  = l;
`else
    if (l) $display("note: left vector skipped in right-only build");
`endif
  endtask

  // From a negedge just after the accept edge's cycle, wait for done.
  // lat = negedges from accept edge to done; bok = busy high on every earlier one.
  task automatic wait_done(output int lat, output bit bok);
    lat = 0;
    bok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) bok = 1'b0;
    end
  endtask

  // Issue one operation, scramble the operand lines after accept, check results.
  task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] s,
                        input logic a, input logic l, input logic [31:0] exp);
    int lat;
    bit bok;
    @(negedge clk);
    drive(1'b1, d, s, a, l);
    @(posedge clk);
    #1;
    drive(1'b0, ~d, ~s, ~a, ~l);
    wait_done(lat, bok);
    check({name, " latency"}, 32'(lat), 32'(s) + 32'd1);
    check({name, " busy during shift"}, {31'd0, bok}, 32'd1);
    check({name, " busy low at done"}, {31'd0, bus.busy}, 32'd0);
    check({name, " out"}, bus.out, exp);
  endtask

  initial begin
    int lat;
    bit bok;
    n_checks = 0;
    n_fail   = 0;

    vecs.push_back('{"srl_f0_by4",   32'hF000_0000, 5'd4,  1'b0, 1'b0, 32'h0F00_0000});
    vecs.push_back('{"sra_neg_by31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF});
    vecs.push_back('{"srl_msb_by31", 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001});
    vecs.push_back('{"zero_shift",   32'h1234_5678, 5'd0,  1'b1, 1'b0, 32'h1234_5678});
    vecs.push_back('{"sra_f0_by4",   32'hF000_0000, 5'd4,  1'b1, 1'b0, 32'hFF00_0000});
    vecs.push_back('{"srl_dead_16",  32'hDEAD_BEEF, 5'd16, 1'b0, 1'b0, 32'h0000_DEAD});
    vecs.push_back('{"sra_pos_30",   32'h7FFF_FFFF, 5'd30, 1'b1, 1'b0, 32'h0000_0001});
    vecs.push_back('{"sra_by1",      32'h8000_0001, 5'd1,  1'b1, 1'b0, 32'hC000_0000});
`ifdef SEQ_SHIFT_LEFT_EN
    vecs.push_back('{"sll_1_by2",    32'h0000_0001, 5'd2,  1'b0, 1'b1, 32'h0000_0004});
    vecs.push_back('{"sll_arith_ign",32'h4000_0000, 5'd1,  1'b1, 1'b1, 32'h8000_0000});
`endif

    // Reset state
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("reset out",  bus.out, 32'h0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].din, vecs[i].sh, vecs[i].ar, vecs[i].lf, vecs[i].exp);
    end

    // Start while busy is ignored; restart in the done cycle has no bubble.
    @(negedge clk);
    drive(1'b1, 32'h0000_0100, 5'd8, 1'b0, 1'b0);
    @(negedge clk);                               // k=1
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);                               // k=2: issue ignored request
    drive(1'b1, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
    @(negedge clk);                               // k=3
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    check("busy start ignored busy", {31'd0, bus.busy}, 32'd1);
    lat = 0;
    for (int k = 4; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("busy start latency", 32'(lat), 32'd9);
    check("busy start out", bus.out, 32'h0000_0001);
    drive(1'b1, 32'h0000_0008, 5'd3, 1'b0, 1'b0);  // in the done cycle
    @(posedge clk);
    #1;
    drive(1'b0, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0);
    wait_done(lat, bok);
    check("b2b latency", 32'(lat), 32'd4);
    check("b2b busy", {31'd0, bok}, 32'd1);
    check("b2b out", bus.out, 32'h0000_0001);
    @(negedge clk);
    check("b2b idle done", {31'd0, bus.done}, 32'd0);
    check("idle hold out", bus.out, 32'h0000_0001);

    // Asynchronous reset mid-shift
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFF, 5'd20, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out",  bus.out, 32'h0);
    check("async rst busy", {31'd0, bus.busy}, 32'd0);
    check("async rst done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst idle busy", {31'd0, bus.busy}, 32'd0);
    run_op("sra_after_rst", 32'hFFFF_FF00, 5'd8, 1'b1, 1'b0, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_right.md
Name: seq_shift_right

Overview:
- Multi-cycle right shifter for the MIPS datapath: executes SRL, SRLV, SRA and SRAV by shifting one bit per clock.
- Companion of the fixed left-shift-by-2 used for branch and jump targets; covers the other direction with a variable amount.
- Sits beside the ALU; the control unit stalls the pipeline while `busy` is high.
- Start/done handshake; a single clock domain.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE or DONE.
- in  input  WIDTH  operand (rt value).
- shamt  input  SHAMT_W  shift amount (instruction field or rs[4:0]).
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- out  output  WIDTH  result register.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse; `out` is valid.

Behaviour:
- Reset (async, rst=1): state=IDLE, out=0, count=0, busy=0, done=0. Reset takes effect immediately, mid-operation included, and discards the operation in flight.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE). Both are registered state decodes and glitch-free.
- Accept: `start` high at a rising edge while in IDLE or DONE. At that edge:
  - latch in into the shift register (`out`);
  - latch shamt into count;
  - latch arith into fill_mode;
  - next state = DONE if shamt==0, else SHIFT.
- SHIFT, each edge:
  - out <= {fill, out[WIDTH-1:1]}, where fill = fill_mode ? out[WIDTH-1] : 0. The MSB is preserved, so sign replication is correct.
  - count <= count-1.
  - if count==1, next state = DONE.
- DONE: lasts exactly one cycle. Next state is IDLE, or a new load if `start` is high (back-to-back issue, no bubble).
- Latency: start high in cycle c gives done high in cycle c+1+shamt.
  - shamt=0: done in c+1, out = in.
  - shamt=31: done in c+32.
- `start` while in SHIFT is ignored; no queuing and no error flag. The controller must wait for `done`.
- Changes on in, shamt or arith after the accept edge have no effect. They are latched.
- `out` shows intermediate values during SHIFT. It is architecturally valid from the done cycle until the next accepted start, and holds indefinitely in IDLE.
- shamt >= WIDTH (only possible if SHAMT_W is overprovisioned): shifting continues for shamt cycles; the result saturates to all-fill bits.

Optional Feature:
- Macro: SEQ_SHIFT_LEFT_EN.
- Defined:
  - adds input port `left` (1 bit), latched at accept with the other operands;
  - left=1 gives a logical left shift, out <= {out[WIDTH-2:0],1'b0}, and arith is ignored;
  - left=0 gives the right-shift behaviour above;
  - timing, handshake and reset are identical in both modes;
  - the unit then also serves SLL and SLLV.
- Undefined: no `left` port; right shifts only.

Test Plan:
- SRL: in=0xF000_0000, shamt=4, arith=0, start in cycle c -> busy high c+1..c+4; done in c+5; out=0x0F00_0000.
- SRA: in=0x8000_0000, shamt=31, arith=1 -> done in c+32, out=0xFFFF_FFFF. Same with arith=0 -> out=0x0000_0001.
- Zero shift: in=0x1234_5678, shamt=0 -> done in c+1, busy never high, out=0x1234_5678.
- Start while busy: second start (in=0xFFFF_FFFF, shamt=1) issued in c+2 of an SRL 0x0000_0100 by 8 -> ignored; done in c+9 with out=0x0000_0001. Then start in that done cycle (0x8 by 3) -> accepted, done 4 cycles later, out=0x1.
- Reset mid-shift: assert rst asynchronously during SHIFT (between edges) -> out=0, busy=0, done=0 immediately. After release, a new SRA 0xFFFF_FF00 by 8 -> out=0xFFFF_FFFF.
- With SEQ_SHIFT_LEFT_EN: left=1, in=0x0000_0001, shamt=2 -> done in c+3, out=0x0000_0004. left=1, arith=1, in=0x4000_0000, shamt=1 -> out=0x8000_0000 (arith ignored).
